// File: rtl/r_type_pipe_if.sv
// r_type_pipe_if
// Bundles the instruction issue, external register write, debug read and
// retirement signals of the two-stage R-type execution unit.
//   in_valid / instruction      : instruction issue (no backpressure)
//   ext_we / ext_waddr / ext_wdata : external register-file write port
//   dbg_raddr / dbg_rdata       : combinational register-file read port
//   out_valid / result / out_rd / illegal : retirement of the EX instruction
// master = issuing side (front end / bench), slave = execution unit.
interface r_type_pipe_if #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
);
    localparam int RA = $clog2(NREGS);

    logic            in_valid;
    logic [31:0]     instruction;
    logic            ext_we;
    logic [RA-1:0]   ext_waddr;
    logic [XLEN-1:0] ext_wdata;
    logic [RA-1:0]   dbg_raddr;
    logic [XLEN-1:0] dbg_rdata;
    logic            out_valid;
    logic [XLEN-1:0] result;
    logic [RA-1:0]   out_rd;
    logic            illegal;

    modport master (
        output in_valid, instruction, ext_we, ext_waddr, ext_wdata, dbg_raddr,
        input  dbg_rdata, out_valid, result, out_rd, illegal
    );

    modport slave (
        input  in_valid, instruction, ext_we, ext_waddr, ext_wdata, dbg_raddr,
        output dbg_rdata, out_valid, result, out_rd, illegal
    );
endinterface

// File: rtl/r_type_pipe.sv
// r_type_pipe
// Two-stage RISC-V R-type execution unit with an integrated register file.
// Stage ID decodes the instruction and reads (or forwards) operands into the
// ID/EX register; stage EX computes the ALU result, registers it on the
// output port and writes it back to the register file.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : r_type_pipe_if.slave (issue, external write, debug read, retire)
module r_type_pipe #(
    parameter int XLEN     = 64,
    parameter int NREGS    = 32,
    parameter int ENABLE_W = 1
) (
    input  logic           clk,
    input  logic           reset,
    r_type_pipe_if.slave   bus
);
    localparam int RA  = $clog2(NREGS);
    localparam int SHW = $clog2(XLEN);
    // Word ops only exist on a 64-bit datapath.
    localparam bit W_EN = (XLEN == 64) && (ENABLE_W != 0);

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
        OP_OR, OP_AND, OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW
    } alu_op_e;

    function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    // Instruction fields
    logic [6:0] w_opcode;
    logic [6:0] w_funct7;
    logic [2:0] w_funct3;
    logic [4:0] w_rs1_f;
    logic [4:0] w_rs2_f;
    logic [4:0] w_rd_f;

    assign w_opcode = bus.instruction[6:0];
    assign w_rd_f   = bus.instruction[11:7];
    assign w_funct3 = bus.instruction[14:12];
    assign w_rs1_f  = bus.instruction[19:15];
    assign w_rs2_f  = bus.instruction[24:20];
    assign w_funct7 = bus.instruction[31:25];

    logic [RA-1:0] w_rs1;
    logic [RA-1:0] w_rs2;
    logic [RA-1:0] w_rd;
    assign w_rs1 = w_rs1_f[RA-1:0];
    assign w_rs2 = w_rs2_f[RA-1:0];
    assign w_rd  = w_rd_f[RA-1:0];

    // Register fields naming a register beyond NREGS make the instruction illegal.
    logic w_fld_ok;
    assign w_fld_ok = ({1'b0, w_rs1_f} < 6'(NREGS)) &&
                      ({1'b0, w_rs2_f} < 6'(NREGS)) &&
                      ({1'b0, w_rd_f}  < 6'(NREGS));

    // Pipeline registers
    logic                   r_ex_vld_p1;
    logic signed [XLEN-1:0] r_a_p1;
    logic signed [XLEN-1:0] r_b_p1;
    logic [RA-1:0]          r_rd_p1;
    alu_op_e                r_op_p1;
    logic                   r_ill_p1;

    logic                   r_vld_p2;
    logic [XLEN-1:0]        r_result_p2;
    logic [RA-1:0]          r_rd_p2;
    logic                   r_ill_p2;

    logic [XLEN-1:0]        r_regs [NREGS];

    // ---------------- Stage ID: decode, operand read, forwarding ----------------
    alu_op_e w_op;
    logic    w_legal_enc;
    logic    w_legal;

    always_comb begin
        w_op        = OP_ADD;
        w_legal_enc = 1'b0;
        if (w_opcode == 7'b0110011) begin
            if (w_funct7 == 7'b0000000) begin
                w_legal_enc = 1'b1;
                case (w_funct3)
                    3'b000:  w_op = OP_ADD;
                    3'b001:  w_op = OP_SLL;
                    3'b010:  w_op = OP_SLT;
                    3'b011:  w_op = OP_SLTU;
                    3'b100:  w_op = OP_XOR;
                    3'b101:  w_op = OP_SRL;
                    3'b110:  w_op = OP_OR;
                    default: w_op = OP_AND;
                endcase
            end else if (w_funct7 == 7'b0100000) begin
                if (w_funct3 == 3'b000) begin
                    w_legal_enc = 1'b1;
                    w_op        = OP_SUB;
                end else if (w_funct3 == 3'b101) begin
                    w_legal_enc = 1'b1;
                    w_op        = OP_SRA;
                end
            end
        end else if (W_EN && (w_opcode == 7'b0111011)) begin
            if (w_funct7 == 7'b0000000) begin
                case (w_funct3)
                    3'b000:  begin w_legal_enc = 1'b1; w_op = OP_ADDW; end
                    3'b001:  begin w_legal_enc = 1'b1; w_op = OP_SLLW; end
                    3'b101:  begin w_legal_enc = 1'b1; w_op = OP_SRLW; end
                    default: ;
                endcase
            end else if (w_funct7 == 7'b0100000) begin
                case (w_funct3)
                    3'b000:  begin w_legal_enc = 1'b1; w_op = OP_SUBW; end
                    3'b101:  begin w_legal_enc = 1'b1; w_op = OP_SRAW; end
                    default: ;
                endcase
            end
        end
    end

    assign w_legal = w_legal_enc && w_fld_ok;

    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_rf_a;
    logic [XLEN-1:0] w_rf_b;
    logic [XLEN-1:0] w_opa;
    logic [XLEN-1:0] w_opb;
    logic            w_ex_we;

    // Only a legal EX instruction targeting a real register produces a value.
    assign w_ex_we = r_ex_vld_p1 && !r_ill_p1 && (r_rd_p1 != '0);

    assign w_rf_a = (w_rs1 == '0) ? '0 : r_regs[w_rs1];
    assign w_rf_b = (w_rs2 == '0) ? '0 : r_regs[w_rs2];
    assign w_opa  = (w_ex_we && (r_rd_p1 == w_rs1)) ? w_alu : w_rf_a;
    assign w_opb  = (w_ex_we && (r_rd_p1 == w_rs2)) ? w_alu : w_rf_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ex_vld_p1 <= 1'b0;
            r_a_p1      <= '0;
            r_b_p1      <= '0;
            r_rd_p1     <= '0;
            r_op_p1     <= OP_ADD;
            r_ill_p1    <= 1'b0;
        end else begin
            r_ex_vld_p1 <= bus.in_valid;
            if (bus.in_valid) begin
                r_a_p1   <= w_opa;
                r_b_p1   <= w_opb;
                r_rd_p1  <= w_rd;
                r_op_p1  <= w_op;
                r_ill_p1 <= !w_legal;
            end
        end
    end

    // ---------------- Stage EX: ALU, result register, writeback ----------------
    logic signed [31:0] w_a32;
    logic signed [31:0] w_b32;
    logic [SHW-1:0]     w_sh;
    assign w_a32 = r_a_p1[31:0];
    assign w_b32 = r_b_p1[31:0];
    assign w_sh  = r_b_p1[SHW-1:0];

    always_comb begin
        w_alu = '0;
        case (r_op_p1)
            OP_ADD:  w_alu = r_a_p1 + r_b_p1;
            OP_SUB:  w_alu = r_a_p1 - r_b_p1;
            OP_SLL:  w_alu = r_a_p1 << w_sh;
            OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, (r_a_p1 < r_b_p1)};
            OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, ($unsigned(r_a_p1) < $unsigned(r_b_p1))};
            OP_XOR:  w_alu = r_a_p1 ^ r_b_p1;
            OP_SRL:  w_alu = $unsigned(r_a_p1) >> w_sh;
            OP_SRA:  w_alu = r_a_p1 >>> w_sh;
            OP_OR:   w_alu = r_a_p1 | r_b_p1;
            OP_AND:  w_alu = r_a_p1 & r_b_p1;
            OP_ADDW: w_alu = sext32(w_a32 + w_b32);
            OP_SUBW: w_alu = sext32(w_a32 - w_b32);
            OP_SLLW: w_alu = sext32(w_a32 << w_b32[4:0]);
            OP_SRLW: w_alu = sext32($unsigned(w_a32) >> w_b32[4:0]);
            OP_SRAW: w_alu = sext32(w_a32 >>> w_b32[4:0]);
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld_p2    <= 1'b0;
            r_result_p2 <= '0;
            r_rd_p2     <= '0;
            r_ill_p2    <= 1'b0;
        end else begin
            r_vld_p2 <= r_ex_vld_p1;
            if (r_ex_vld_p1) begin
                r_result_p2 <= r_ill_p1 ? '0 : w_alu;
                r_rd_p2     <= r_rd_p1;
                r_ill_p2    <= r_ill_p1;
            end
        end
    end

    // EX writeback has priority over an external write to the same register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_ex_we) begin
                r_regs[r_rd_p1] <= w_alu;
            end
            if (bus.ext_we && (bus.ext_waddr != '0) &&
                !(w_ex_we && (bus.ext_waddr == r_rd_p1))) begin
                r_regs[bus.ext_waddr] <= bus.ext_wdata;
            end
        end
    end

    assign bus.dbg_rdata = (bus.dbg_raddr == '0) ? '0 : r_regs[bus.dbg_raddr];
    assign bus.out_valid = r_vld_p2;
    assign bus.result    = r_result_p2;
    assign bus.out_rd    = r_rd_p2;
    assign bus.illegal   = r_ill_p2;
endmodule

// File: tb/tb_r_type_pipe.sv
module tb_r_type_pipe;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    r_type_pipe_if #(.XLEN(64), .NREGS(32)) bus0 ();
    r_type_pipe_if #(.XLEN(64), .NREGS(16)) bus1 ();

    r_type_pipe #(.XLEN(64), .NREGS(32), .ENABLE_W(1)) u0 (.clk(clk), .reset(rst_n), .bus(bus0));
    r_type_pipe #(.XLEN(64), .NREGS(16), .ENABLE_W(0)) u1 (.clk(clk), .reset(rst_n), .bus(bus1));

    int nchk  = 0;
    int nfail = 0;
    bit chk_en = 0;

    // Architectural model: register state per instance plus the one
    // instruction that has issued but not yet retired.
    logic [63:0] m    [2][32];
    bit          pv   [2];
    bit          pill [2];
    logic [63:0] pres [2];
    int          prd  [2];
    bit          ev   [2];
    bit          eill [2];
    logic [63:0] eres [2];
    int          erd  [2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic void mexec(input logic [31:0] ins, input logic [63:0] a,
                                  input logic [63:0] b, input int nr, input bit enw,
                                  output logic [63:0] res, output bit ill);
        logic [6:0]  op;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] w;
        op  = ins[6:0];
        f7  = ins[31:25];
        f3  = ins[14:12];
        res = 64'd0;
        ill = 1'b0;
        w   = 32'd0;
        if (int'(ins[19:15]) >= nr || int'(ins[24:20]) >= nr || int'(ins[11:7]) >= nr) begin
            ill = 1'b1;
        end else if (op == 7'h33 && f7 == 7'h00) begin
            case (f3)
                3'd0: res = a + b;
                3'd1: res = a << b[5:0];
                3'd2: res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
                3'd3: res = (a < b) ? 64'd1 : 64'd0;
                3'd4: res = a ^ b;
                3'd5: res = a >> b[5:0];
                3'd6: res = a | b;
                default: res = a & b;
            endcase
        end else if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0) begin
            res = a - b;
        end else if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd5) begin
            res = $signed(a) >>> b[5:0];
        end else if (op == 7'h3B && enw && f7 == 7'h00 && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)) begin
            if (f3 == 3'd0)      w = a[31:0] + b[31:0];
            else if (f3 == 3'd1) w = a[31:0] << b[4:0];
            else                 w = a[31:0] >> b[4:0];
            res = {{32{w[31]}}, w};
        end else if (op == 7'h3B && enw && f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
            if (f3 == 3'd0) w = a[31:0] - b[31:0];
            else            w = $signed(a[31:0]) >>> b[4:0];
            res = {{32{w[31]}}, w};
        end else begin
            ill = 1'b1;
        end
        if (ill) res = 64'd0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) m[k][i] = 64'd0;
            pv[k] = 0; pill[k] = 0; pres[k] = 0; prd[k] = 0;
            ev[k] = 0; eill[k] = 0; eres[k] = 0; erd[k] = 0;
        end
    endtask

    // One clock edge seen architecturally: retire, issue, then external write.
    task automatic model_edge(input bit v, input logic [31:0] ins, input bit we,
                              input logic [4:0] wa, input logic [63:0] wd);
        for (int k = 0; k < 2; k++) begin
            int nr;
            int mask;
            bit wrote;
            int rd_old;
            int ea;
            nr   = (k == 0) ? 32 : 16;
            mask = nr - 1;
            ev[k] = pv[k];
            if (pv[k]) begin
                eres[k] = pres[k];
                erd[k]  = prd[k];
                eill[k] = pill[k];
            end
            wrote  = pv[k] && !pill[k] && prd[k] != 0;
            rd_old = prd[k];
            if (wrote) m[k][prd[k]] = pres[k];
            pv[k] = v;
            if (v) begin
                mexec(ins, m[k][int'(ins[19:15]) & mask], m[k][int'(ins[24:20]) & mask],
                      nr, (k == 0), pres[k], pill[k]);
                prd[k] = int'(ins[11:7]) & mask;
            end
            ea = int'(wa) & mask;
            if (we && ea != 0 && !(wrote && ea == rd_old)) m[k][ea] = wd;
        end
    endtask

    task automatic cyc(input bit v, input logic [31:0] ins, input bit we,
                       input logic [4:0] wa, input logic [63:0] wd);
        bus0.in_valid = v;    bus1.in_valid = v;
        bus0.instruction = ins; bus1.instruction = ins;
        bus0.ext_we = we;     bus1.ext_we = we;
        bus0.ext_waddr = wa;  bus1.ext_waddr = wa[3:0];
        bus0.ext_wdata = wd;  bus1.ext_wdata = wd;
        bus0.dbg_raddr = 5'($urandom);
        bus1.dbg_raddr = 4'($urandom);
        @(posedge clk);
        #1;
        model_edge(v, ins, we, wa, wd);
    endtask

    task automatic rd_check(input int k, input int a, input logic [63:0] exp, input string nm);
        if (k == 0) bus0.dbg_raddr = 5'(a);
        else        bus1.dbg_raddr = 4'(a);
        #1;
        chk(nm, (k == 0) ? bus0.dbg_rdata : bus1.dbg_rdata, exp);
    endtask

    task automatic cmp(input int k, input logic ov, input logic [63:0] res, input logic [4:0] rd,
                       input logic ill, input logic [4:0] da, input logic [63:0] dd);
        int mask;
        mask = (k == 0) ? 31 : 15;
        chk($sformatf("u%0d.out_valid", k), 64'(ov), 64'(ev[k]));
        if (ev[k]) begin
            chk($sformatf("u%0d.result", k), res, eres[k]);
            chk($sformatf("u%0d.out_rd", k), 64'(rd), 64'(erd[k]));
            chk($sformatf("u%0d.illegal", k), 64'(ill), 64'(eill[k]));
        end
        chk($sformatf("u%0d.dbg_rdata[%0d]", k, da), dd, m[k][int'(da) & mask]);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, bus0.out_valid, bus0.result, bus0.out_rd, bus0.illegal, bus0.dbg_raddr, bus0.dbg_rdata);
            cmp(1, bus1.out_valid, bus1.result, {1'b0, bus1.out_rd}, bus1.illegal,
                {1'b0, bus1.dbg_raddr}, bus1.dbg_rdata);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  op;
        logic [6:0]  f7;
        logic [63:0] wd;
        rst_n = 1'b0;
        bus0.in_valid = 0; bus0.instruction = 0; bus0.ext_we = 0; bus0.ext_waddr = 0;
        bus0.ext_wdata = 0; bus0.dbg_raddr = 5;
        bus1.in_valid = 0; bus1.instruction = 0; bus1.ext_we = 0; bus1.ext_waddr = 0;
        bus1.ext_wdata = 0; bus1.dbg_raddr = 5;
        model_reset();
        #7;
        chk("reset out_valid", 64'(bus0.out_valid), 64'd0);
        chk("reset result", bus0.result, 64'd0);
        chk("reset out_rd", 64'(bus0.out_rd), 64'd0);
        chk("reset illegal", 64'(bus0.illegal), 64'd0);
        chk("reset x5", bus0.dbg_rdata, 64'd0);
        #1;
        rst_n  = 1'b1;
        chk_en = 1;

        // Preload xi = i, then try to write x0.
        for (int i = 0; i < 32; i++) cyc(0, 0, 1, 5'(i), 64'(i));
        cyc(0, 0, 1, 5'd0, 64'hFF);
        for (int i = 0; i < 32; i++) begin
            cyc(0, 0, 0, 0, 0);
            rd_check(0, i, 64'(i), $sformatf("preload x%0d", i));
        end

        // ADD then dependent SUB.
        cyc(1, 32'h00638333, 0, 0, 0);
        cyc(1, 32'h40638333, 0, 0, 0);
        chk("ADD result", bus0.result, 64'd13);
        chk("ADD out_rd", 64'(bus0.out_rd), 64'd6);
        cyc(0, 0, 0, 0, 0);
        chk("SUB fwd result", bus0.result, 64'hFFFF_FFFF_FFFF_FFFA);

        // Signed/unsigned compare and shifts.
        cyc(0, 0, 1, 5'd1, 64'h8000_0000_0000_0000);
        cyc(0, 0, 1, 5'd2, 64'd1);
        cyc(1, enc(7'h00, 2, 1, 3'd2, 3, 7'h33), 0, 0, 0);
        cyc(1, enc(7'h00, 2, 1, 3'd3, 3, 7'h33), 0, 0, 0);
        chk("SLT result", bus0.result, 64'd1);
        cyc(1, enc(7'h20, 2, 1, 3'd5, 3, 7'h33), 0, 0, 0);
        chk("SLTU result", bus0.result, 64'd0);
        cyc(1, enc(7'h00, 2, 1, 3'd5, 3, 7'h33), 0, 0, 0);
        chk("SRA result", bus0.result, 64'hC000_0000_0000_0000);
        cyc(0, 0, 0, 0, 0);
        chk("SRL result", bus0.result, 64'h4000_0000_0000_0000);

        // ADDW, and the same encoding on the unit without word ops.
        cyc(0, 0, 1, 5'd1, 64'h7FFF_FFFF);
        cyc(0, 0, 1, 5'd2, 64'd1);
        cyc(1, enc(7'h00, 2, 1, 3'd0, 3, 7'h3B), 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("ADDW result", bus0.result, 64'hFFFF_FFFF_8000_0000);
        chk("ADDW noW illegal", 64'(bus1.illegal), 64'd1);
        chk("ADDW noW result", bus1.result, 64'd0);
        rd_check(1, 3, 64'h4000_0000_0000_0000, "ADDW noW x3 kept");

        // Bad funct7.
        cyc(1, 32'h02000033, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("bad funct7 illegal", 64'(bus0.illegal), 64'd1);
        chk("bad funct7 result", bus0.result, 64'd0);

        // EX writeback and external write to x5 on the same edge.
        cyc(1, enc(7'h00, 2, 1, 3'd0, 5, 7'h33), 0, 0, 0);
        cyc(0, 0, 1, 5'd5, 64'hDEAD);
        rd_check(0, 5, 64'h8000_0000, "WB beats ext x5");

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            case ($urandom % 8)
                0, 1, 2, 3: op = 7'h33;
                4, 5, 6:    op = 7'h3B;
                default:    op = 7'($urandom);
            endcase
            case ($urandom % 4)
                0, 1:    f7 = 7'h00;
                2:       f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            case ($urandom % 5)
                0:       wd = 64'h8000_0000_0000_0000;
                1:       wd = 64'h7FFF_FFFF;
                2:       wd = 64'(32'($urandom));
                default: wd = {$urandom, $urandom};
            endcase
            cyc(($urandom % 4) != 0,
                enc(f7, ($urandom % 3 == 0) ? 5'($urandom) : 5'($urandom % 6),
                    ($urandom % 3 == 0) ? 5'($urandom) : 5'($urandom % 6), 3'($urandom),
                    ($urandom % 3 == 0) ? 5'($urandom) : 5'($urandom % 6), op),
                ($urandom % 3) == 0, ($urandom % 2 == 0) ? 5'($urandom) : 5'($urandom % 6), wd);
        end

        // Reset between E0 and E1 of an ADD to x8.
        cyc(0, 0, 1, 5'd1, 64'd3);
        cyc(1, enc(7'h00, 2, 1, 3'd0, 7, 7'h33), 0, 0, 0);
        cyc(1, enc(7'h00, 2, 1, 3'd0, 8, 7'h33), 0, 0, 0);
        chk_en = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 64'(bus0.out_valid), 64'd0);
        chk("async rst result", bus0.result, 64'd0);
        chk("async rst out_rd", 64'(bus0.out_rd), 64'd0);
        chk("async rst illegal", 64'(bus0.illegal), 64'd0);
        chk("async rst u1 out_valid", 64'(bus1.out_valid), 64'd0);
        model_reset();
        bus0.in_valid = 0; bus1.in_valid = 0;
        bus0.ext_we = 1; bus1.ext_we = 1;
        bus0.ext_waddr = 5'd9; bus1.ext_waddr = 4'd9;
        bus0.ext_wdata = 64'd5; bus1.ext_wdata = 64'd5;
        @(posedge clk);
        #1;
        chk("in rst out_valid", 64'(bus0.out_valid), 64'd0);
        rst_n = 1'b1;
        bus0.ext_we = 0; bus1.ext_we = 0;
        rd_check(0, 9, 64'd0, "write ignored in reset x9");
        rd_check(0, 8, 64'd0, "rst dest x8");
        rd_check(0, 7, 64'd0, "rst cleared x7");
        chk_en = 1;
        for (int n = 0; n < 50; n++) begin
            cyc(($urandom % 2) == 0, enc(7'h00, 5'($urandom % 6), 5'($urandom % 6), 3'($urandom),
                5'($urandom % 6), 7'h33), ($urandom % 2) == 0, 5'($urandom % 6), {$urandom, $urandom});
        end
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
